// File: rtl/execute_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface execute_if;
    logic        RegWriteE, MemWriteE, MemtoRegE;
    logic        BranchE, JumpE, JalrE, LinkE;
    logic        ALUSrcE, MulDivE;
    logic [3:0]  ALUCtrlE;
    logic [2:0]  Funct3E;
    logic [31:0] r1E, r2E, ImmE, PCE;
    logic [4:0]  rdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallE;
    logic [2:0]  strCtrlM;
    logic        RegWriteM, MemWriteM, MemtoRegM;
    logic [31:0] ALUoutM, PCplusImmM, r2M;
    logic [4:0]  rdM;

    modport master (
        output RegWriteE, MemWriteE, MemtoRegE,
        output BranchE, JumpE, JalrE, LinkE,
        output ALUSrcE, MulDivE, ALUCtrlE, Funct3E,
        output r1E, r2E, ImmE, PCE, rdE,
        output ForwardAE, ForwardBE, ResultW, FlushE,
        input  PCSrcE, PCTargetE, StallE,
        input  strCtrlM, RegWriteM, MemWriteM, MemtoRegM,
        input  ALUoutM, PCplusImmM, r2M, rdM
    );

    modport slave (
        input  RegWriteE, MemWriteE, MemtoRegE,
        input  BranchE, JumpE, JalrE, LinkE,
        input  ALUSrcE, MulDivE, ALUCtrlE, Funct3E,
        input  r1E, r2E, ImmE, PCE, rdE,
        input  ForwardAE, ForwardBE, ResultW, FlushE,
        output PCSrcE, PCTargetE, StallE,
        output strCtrlM, RegWriteM, MemWriteM, MemtoRegM,
        output ALUoutM, PCplusImmM, r2M, rdM
    );
endinterface

// File: rtl/execute.sv
// RV32IM execute stage: forwarding, ALU, branch resolution, multiplier,
// iterative divider with stall, and the EX/MEM pipeline register.
module execute #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input logic      clk,
    input logic      rst,
    execute_if.slave ex
);
    localparam int CW = $clog2(DIV_STEPS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

    logic [XLEN-1:0] srcA, srcB, aluB, aluRes, mulRes, divRes, resultE;
    logic [XLEN-1:0] pcPlusImm, jalrTgt;
    logic            eq, lt, ltu, cond;

    always_comb begin
        unique case (ex.ForwardAE)
            2'b01:   srcA = ex.ResultW;
            2'b10:   srcA = ex.ALUoutM;
            default: srcA = ex.r1E;
        endcase
        unique case (ex.ForwardBE)
            2'b01:   srcB = ex.ResultW;
            2'b10:   srcB = ex.ALUoutM;
            default: srcB = ex.r2E;
        endcase
    end

    assign aluB = ex.ALUSrcE ? ex.ImmE : srcB;

    always_comb begin
        unique case (ex.ALUCtrlE)
            4'd0:    aluRes = srcA + aluB;
            4'd1:    aluRes = srcA - aluB;
            4'd2:    aluRes = srcA << aluB[4:0];
            4'd3:    aluRes = {31'b0, $signed(srcA) < $signed(aluB)};
            4'd4:    aluRes = {31'b0, srcA < aluB};
            4'd5:    aluRes = srcA ^ aluB;
            4'd6:    aluRes = srcA >> aluB[4:0];
            4'd7:    aluRes = $signed(srcA) >>> aluB[4:0];
            4'd8:    aluRes = srcA | aluB;
            4'd9:    aluRes = srcA & aluB;
            4'd10:   aluRes = aluB;
            default: aluRes = '0;
        endcase
    end

    assign eq  = srcA == srcB;
    assign lt  = $signed(srcA) < $signed(srcB);
    assign ltu = srcA < srcB;

    always_comb begin
        unique case (ex.Funct3E)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact.
    logic            mulSA, mulSB;
    logic [63:0]     mulA, mulB, prod;
    assign mulSA  = (ex.Funct3E[1:0] == 2'b01) | (ex.Funct3E[1:0] == 2'b10);
    assign mulSB  = ex.Funct3E[1:0] == 2'b01;
    assign mulA   = {{32{mulSA & srcA[31]}}, srcA};
    assign mulB   = {{32{mulSB & srcB[31]}}, srcB};
    assign prod   = mulA * mulB;
    assign mulRes = (ex.Funct3E[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

    divState_t       state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            negQ, negR, remSel;
    logic            divOp, divReq, divSigned, divZero, divOvf;
    logic [XLEN-1:0] magA, magB;
    logic [XLEN:0]   shifted, diff;

    assign divOp     = ex.MulDivE & ex.Funct3E[2];
    assign divReq    = divOp & ~ex.FlushE;
    assign divSigned = ~ex.Funct3E[0];
    assign magA      = (divSigned & srcA[31]) ? -srcA : srcA;
    assign magB      = (divSigned & srcB[31]) ? -srcB : srcB;
    assign divZero   = srcB == '0;
    assign divOvf    = divSigned & (srcA == 32'h8000_0000)
                     & (srcB == 32'hFFFF_FFFF);
    assign shifted   = {rem, quo[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            negQ   <= 1'b0;
            negR   <= 1'b0;
            remSel <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (divReq) begin
                    remSel <= ex.Funct3E[1];
                    dvs    <= magB;
                    cnt    <= CW'(DIV_STEPS);
                    if (divZero) begin
                        quo   <= '1;
                        rem   <= srcA;
                        negQ  <= 1'b0;
                        negR  <= 1'b0;
                        state <= DONE;
                    end else if (divOvf) begin
                        quo   <= 32'h8000_0000;
                        rem   <= '0;
                        negQ  <= 1'b0;
                        negR  <= 1'b0;
                        state <= DONE;
                    end else begin
                        quo   <= magA;
                        rem   <= '0;
                        negQ  <= divSigned & (srcA[31] ^ srcB[31]);
                        negR  <= divSigned & srcA[31];
                        state <= BUSY;
                    end
                end
                BUSY: if (ex.FlushE) begin
                    state <= IDLE;
                end else begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign divRes = remSel ? (negR ? -rem : rem) : (negQ ? -quo : quo);

    assign ex.StallE = ~rst & (((state == IDLE) & divReq) | (state == BUSY));

    assign pcPlusImm = ex.PCE + ex.ImmE;
    assign jalrTgt   = (srcA + ex.ImmE) & ~32'd1;
    assign ex.PCTargetE = ex.JalrE ? jalrTgt : pcPlusImm;
    assign ex.PCSrcE = (ex.JumpE | (ex.BranchE & cond))
                     & ~ex.FlushE & ~ex.StallE;

    assign resultE = ex.LinkE   ? ex.PCE + 32'd4 :
                     ex.MulDivE ? (ex.Funct3E[2] ? divRes : mulRes) :
                                  aluRes;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex.strCtrlM   <= '0;
            ex.RegWriteM  <= 1'b0;
            ex.MemWriteM  <= 1'b0;
            ex.MemtoRegM  <= 1'b0;
            ex.ALUoutM    <= '0;
            ex.PCplusImmM <= '0;
            ex.r2M        <= '0;
            ex.rdM        <= '0;
        end else begin
            ex.strCtrlM   <= ex.Funct3E;
            ex.ALUoutM    <= resultE;
            ex.PCplusImmM <= pcPlusImm;
            ex.r2M        <= srcB;
            if (ex.FlushE | ex.StallE) begin
                ex.RegWriteM <= 1'b0;
                ex.MemWriteM <= 1'b0;
                ex.MemtoRegM <= 1'b0;
                ex.rdM       <= '0;
            end else begin
                ex.RegWriteM <= ex.RegWriteE;
                ex.MemWriteM <= ex.MemWriteE;
                ex.MemtoRegM <= ex.MemtoRegE;
                ex.rdM       <= ex.rdE;
            end
        end
    end
endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the 5-stage RV32IM pipeline, between the ID/EX register and the memory stage.
- Contains:
  - operand forwarding muxes;
  - the ALU;
  - branch/jump resolution;
  - a single-cycle multiplier;
  - an iterative 32-step divider with a pipeline stall handshake.
- Owns the EX/MEM pipeline register. Its M-suffixed outputs drive the memory stage directly.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- DIV_STEPS, 32, number of divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteE, MemWriteE, MemtoRegE  in  1 each  control bits passed through to M.
- BranchE, JumpE, JalrE, LinkE  in  1 each  branch / JAL / JALR target select / write PC+4 to rd.
- ALUSrcE  in  1  0 = srcB, 1 = ImmE.
- ALUCtrlE  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Others give 0.
- MulDivE  in  1  instruction is an M-extension op.
- Funct3E  in  3  instr[14:12]: branch condition, M op, load/store size.
- r1E, r2E, ImmE, PCE  in  32 each  register operands, immediate, PC.
- rdE  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  00 = register, 01 = ResultW, 10 = ALUoutM. 11 behaves as 00.
- ResultW  in  32  writeback result.
- FlushE  in  1  kill the instruction in EX.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  32  redirect address.
- StallE  out  1  hold IF/ID/EX; EX/MEM receives a bubble.
- strCtrlM  out  3  registered Funct3E.
- RegWriteM, MemWriteM, MemtoRegM  out  1 each  registered control bits.
- ALUoutM, PCplusImmM, r2M  out  32 each  registered result, PCE+ImmE, forwarded srcB.
- rdM  out  5  registered rdE.

Behaviour:
- Reset:
  - All EX/MEM outputs are 0.
  - Divider FSM goes to IDLE; StallE is 0.
  - Reset mid-divide aborts the operation; no result is written.
- Operand selection:
  - srcA and srcB come from the ForwardAE / ForwardBE muxes.
  - ALU B = ALUSrcE ? ImmE : srcB.
  - r2M captures srcB, never the immediate.
- ALU arithmetic:
  - Modulo 2^32.
  - Shift amount = B[4:0].
  - SLT is signed; SLTU is unsigned.
- Result select: LinkE ? PCE+4 : MulDivE ? muldiv result : ALU result.
- Branch condition, by Funct3E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010/011 never taken.
- Redirect:
  - PCSrcE = (JumpE | (BranchE & cond)) & ~FlushE & ~StallE.
  - PCTargetE = JalrE ? (srcA+ImmE) & ~1 : PCE+ImmE.
- Multiplier (MulDivE, Funct3E[2]=0): combinational, result in the same cycle, no stall.
  - 000 MUL = low 32 bits.
  - 001 MULH = signed×signed, high word.
  - 010 MULHSU = signed×unsigned, high word.
  - 011 MULHU = unsigned×unsigned, high word.
- Divider (MulDivE, Funct3E[2]=1): 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE → BUSY when a divide is in EX and FlushE=0.
    - On this edge the operands are latched, converted to magnitudes with the result signs recorded, and the step counter is loaded with DIV_STEPS.
  - BUSY: one restoring shift-subtract step per cycle. Counter reaches 0 → DONE.
  - DONE: result applied to EX/MEM this cycle → IDLE.
- Divider stall:
  - StallE is 1 in the issue cycle (IDLE with a divide present) and throughout BUSY. It is 0 in DONE.
  - A divide therefore spends DIV_STEPS+2 = 34 cycles in EX, with StallE high for 33.
- Latched operands are used throughout the divide. Forwarding sources changing during the stall have no effect.
- Divider special cases, detected at issue, skip BUSY (IDLE → DONE, one stall cycle):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / −1: quotient = 0x80000000, remainder = 0.
- Result signs: the quotient is negated if the operand signs differ (signed ops). The remainder takes the dividend's sign.
- EX/MEM register, each edge with rst=0:
  - If FlushE or StallE: control outputs (RegWriteM, MemWriteM, MemtoRegM) = 0, rdM = 0. Data outputs may hold any value.
  - Otherwise: all fields load from the E-stage values.
- FlushE while in BUSY or DONE: FSM → IDLE, bubble inserted, StallE=0 from the next cycle.
- FlushE takes priority over stall and redirect.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → all M outputs 0, StallE=0.
  - Then ADD with r1E=5, ImmE=−3 (0xFFFFFFFD), ALUSrcE=1 → ALUoutM=2, RegWriteM=1 on the next edge.
- Forwarding: ForwardAE=10 with ALUoutM=0x10, ForwardBE=01 with ResultW=0x20, SUB → ALUoutM=0xFFFFFFF0, r2M=0x20.
- Branch/JALR:
  - BLT with srcA=−1, srcB=1 → PCSrcE=1, PCTargetE=PCE+ImmE.
  - BLTU with the same operands → PCSrcE=0.
  - JALR with srcA=0x1003, ImmE=0 → PCTargetE=0x1002, ALUoutM=PCE+4.
- Multiply: MULH of 0x80000000 × 2 → 0xFFFFFFFF. MULHU of the same operands → 0x00000001. No stall.
- Divide: DIV −7/2 → StallE high for exactly 33 cycles, bubbles in EX/MEM, then ALUoutM=0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/0 → 0xFFFFFFFF after 1 stall cycle.
  - DIV 0x80000000/−1 → 0x80000000.
- Abort: FlushE at cycle 10 of BUSY → StallE low next cycle, RegWriteM=0, and the next ADD completes normally.
  - Repeat the same case with rst instead of FlushE → same result.
